counter_sched: RTL and testbench
================================

Name: counter_sched

Overview:
- Scheduler that shares one external 8-bit loadable up-counter (load/data/cin inputs, out/cout outputs) among NREQ requesters.
- Each requester submits a start value and a repeat count.
- The block grants requesters round-robin, loads the counter, runs it to wrap-around (cout) the requested number of passes, then signals completion to the owner.
- Sits between client logic and the counter datapath; it is the only driver of the counter's load, data and cin inputs.

Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 8, counter/data width
- REP_W, 4, repeat-count width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_data  in  NREQ*WIDTH  start value; slice i belongs to requester i
- req_reps  in  NREQ*REP_W  extra passes; slice i belongs to requester i
- ack  out  NREQ  one-cycle grant/accept pulse, one-hot
- done  out  NREQ  one-cycle completion pulse, one-hot
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(NREQ)  current owner; valid while busy
- hold  in  1  pause: forces cnt_cin=0 while in RUN
- cnt_load  out  1  to counter load
- cnt_data  out  WIDTH  to counter data
- cnt_cin  out  1  to counter cin
- cnt_cout  in  1  from counter cout (all-ones AND cin, combinational)

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (any time, including mid-operation) forces:
  - state=IDLE
  - ack, done, busy, grant_id, cnt_load, cnt_cin all 0
  - cnt_data register = 0, reps_left = 0
  - rr pointer last = NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, RUN, DONE. All outputs are Moore-decoded from state and registers, except ack (see IDLE).
- IDLE:
  - If any req bit is high, pick the first set bit scanning last+1, last+2, … mod NREQ.
  - In the same cycle: assert ack[winner], latch req_data/req_reps slices into data_q/reps_left and grant_id; next state LOAD.
  - Requester holds req, req_data and req_reps until it sees ack. Data is sampled only in the ack cycle.
  - A req that drops before ack is never granted.
- LOAD:
  - cnt_load=1, cnt_data=data_q, cnt_cin=0. The counter takes data_q at this edge.
  - Next state RUN.
- RUN:
  - cnt_cin = ~hold; cnt_cout is ignored while hold=1.
  - If cnt_cout=1 (counter at all-ones with cin, wraps to 0 at this edge):
    - reps_left==0 -> next state DONE.
    - otherwise reps_left-1, next state LOAD (reload data_q).
- DONE:
  - done[grant_id]=1 for one cycle; last <= grant_id; next state IDLE.
  - No new grant is issued in the DONE cycle.
- Pass timing:
  - One pass takes 2^WIDTH - data_q RUN cycles without hold.
  - Total passes = reps+1; reps=0 means a single pass.
- Latency (no hold, reps=0): ack in cycle t, LOAD in t+1, RUN from t+2 to t+1+(256-data), done pulse in the following cycle.
- Boundary conditions:
  - data=0xFF: cout in the first RUN cycle.
  - data=0x00: 256 RUN cycles.
  - reps at max (2^REP_W-1): 2^REP_W passes.
  - A requester holding req after done is re-arbitrated normally; round-robin guarantees other pending requesters win first.
  - hold asserted in IDLE/LOAD/DONE has no effect.

Decomposition:
- Package counter_sched_pkg holds:
  - state encoding constants ST_IDLE=0, ST_LOAD=1, ST_RUN=2, ST_DONE=3
  - default WIDTH and REP_W values
- One sub-module, rr_arbiter:
  - parameter NREQ
  - inputs req and last
  - outputs one-hot gnt, binary gnt_id and any
  - purely combinational
- The counter itself stays external and is instantiated alongside in the testbench.

Test Plan:
- Reset, then req[0]=1, data=0xFC, reps=0 -> ack[0] in cycle 0, cnt_load in cycle 1, cnt_cin high for 4 cycles, done[0] in cycle 6, busy low in cycle 7.
- req[1], data=0xFE, reps=2 -> exactly 3 LOAD pulses, 2 RUN cycles each, single done[1]; counter out=0x00 afterwards.
- req[0] and req[1] held continuously, both data=0xFF, reps=0 -> grants alternate 0,1,0,1; no requester granted twice in a row.
- hold=1 for 5 cycles mid-RUN with data=0xF0 -> cnt_cin=0 during hold, done is delayed exactly 5 cycles versus the no-hold run.
- rst_n pulled low during RUN -> all outputs 0 immediately (asynchronous), no done pulse; after release req[0] wins the first grant.
- data=0x00, reps=0 -> 256 RUN cycles between LOAD and DONE.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM encoding and default widths.
package counter_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int WIDTH_DEF = 8;
   localparam int REP_W_DEF = 4;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans last+1, last+2, ... (mod NREQ)
// and grants the first requester found.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] last,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            any
);

   int              idx;
   logic [ID_W-1:0] idx_w;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      idx_w  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_w = ID_W'(idx);
         if (!any && req[idx_w]) begin
            any         = 1'b1;
            gnt[idx_w]  = 1'b1;
            gnt_id      = idx_w;
         end
      end
   end

endmodule

// File: rtl/counter_sched.sv
// Shares one external loadable up-counter among NREQ requesters: grant
// round-robin, load the start value, run to wrap-around reps+1 times, report done.
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter  int NREQ  = 2,
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int REP_W = REP_W_DEF,
   localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ*REP_W-1:0] req_reps,
   output logic [NREQ-1:0]    ack,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic [ID_W-1:0]    grant_id,
   input  logic               hold,
   output logic               cnt_load,
   output logic [WIDTH-1:0]   cnt_data,
   output logic               cnt_cin,
   input  logic               cnt_cout
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [REP_W-1:0] reps_q, reps_d;
   logic [ID_W-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]  last_q, last_d;

   logic [NREQ-1:0]  arb_gnt;
   logic [ID_W-1:0]  arb_id;
   logic             arb_any;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .last   (last_q),
      .gnt    (arb_gnt),
      .gnt_id (arb_id),
      .any    (arb_any)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      reps_d  = reps_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               data_d  = req_data[int'(arb_id)*WIDTH +: WIDTH];
               reps_d  = req_reps[int'(arb_id)*REP_W +: REP_W];
               grant_d = arb_id;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            // cout only counts when we are actually driving cin
            if (!hold && cnt_cout) begin
               if (reps_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  reps_d  = reps_q - 1'b1;
                  state_d = ST_LOAD;
               end
            end
         end
         ST_DONE: begin
            last_d  = grant_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         reps_q  <= '0;
         grant_q <= '0;
         last_q  <= ID_W'(NREQ - 1);
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         reps_q  <= reps_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // ack is the only Mealy output; masked so nothing leaks out while reset is held
   assign ack      = (state_q == ST_IDLE && rst_n) ? arb_gnt : '0;
   assign done     = (state_q == ST_DONE) ? (NREQ'(1) << grant_q) : '0;
   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_q;
   assign cnt_load = (state_q == ST_LOAD);
   assign cnt_data = data_q;
   assign cnt_cin  = (state_q == ST_RUN) && !hold;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched with the external 8-bit counter modelled alongside;
// expected ack/done events are queued by stimulus and checked by a monitor.
module tb_counter_sched;

   localparam int NREQ  = 2;
   localparam int WIDTH = 8;
   localparam int REP_W = 4;

   logic                  clk   = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NREQ-1:0]       req   = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ*REP_W-1:0] req_reps = '0;
   logic                  hold  = 1'b0;
   logic [NREQ-1:0]       ack, done;
   logic                  busy;
   logic [0:0]            grant_id;
   logic                  cnt_load, cnt_cin, cnt_cout;
   logic [WIDTH-1:0]      cnt_data;
   logic [WIDTH-1:0]      cnt_out = '0;

   counter_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .REP_W(REP_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .req_reps (req_reps),
      .ack      (ack),
      .done     (done),
      .busy     (busy),
      .grant_id (grant_id),
      .hold     (hold),
      .cnt_load (cnt_load),
      .cnt_data (cnt_data),
      .cnt_cin  (cnt_cin),
      .cnt_cout (cnt_cout)
   );

   always #5 clk = ~clk;

   // external loadable up-counter
   always @(posedge clk) begin
      if (cnt_load)     cnt_out <= cnt_data;
      else if (cnt_cin) cnt_out <= cnt_out + 8'd1;
   end
   assign cnt_cout = (&cnt_out) & cnt_cin;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit is_done;
      int id;
      int cyc;
   } ev_t;
   ev_t exp_q[$];

   int passed = 0;
   int total  = 0;
   int n_load = 0;
   int n_cin  = 0;

   task automatic chk(input string name, input longint act, input longint need);
      total++;
      if (act == need) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, need);
   endtask

   task automatic push(input bit is_done, input int id, input int c);
      ev_t e;
      e.is_done = is_done;
      e.id      = id;
      e.cyc     = c;
      exp_q.push_back(e);
   endtask

   task automatic check_event(input bit is_done, input logic [NREQ-1:0] vec);
      ev_t   e;
      string nm;
      nm = is_done ? "done" : "ack";
      $display("%s vec=%b cycle=%0d", nm, vec, cyc);
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL %s_unexpected: got vec %b at cycle %0d, required no event", nm, vec, cyc);
      end else begin
         e = exp_q.pop_front();
         chk({nm, "_kind"}, longint'(is_done), longint'(e.is_done));
         chk({nm, "_vec"}, longint'(vec), longint'(1 << e.id));
         chk({nm, "_cycle"}, longint'(cyc), longint'(e.cyc));
      end
   endtask

   // monitor: pops the scoreboard on every ack/done pulse
   always @(negedge clk) begin
      if (cnt_load) n_load++;
      if (cnt_cin)  n_cin++;
      if (ack != '0)  check_event(1'b0, ack);
      if (done != '0) check_event(1'b1, done);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int id, input int limit);
      bit seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge clk);
         seen = ack[id];
      end
      if (!seen) begin
         total++;
         $display("FAIL ack_timeout: got no ack[%0d] within %0d cycles, required one", id, limit);
      end
   endtask

   task automatic wait_idle(input int limit);
      bit idle = 1'b0;
      for (int k = 0; k < limit && !idle; k++) begin
         @(negedge clk);
         idle = !busy;
      end
      if (!idle) begin
         total++;
         $display("FAIL idle_timeout: busy still high after %0d cycles, required low", limit);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_ack"},      longint'(ack), 0);
      chk({pfx, "_done"},     longint'(done), 0);
      chk({pfx, "_busy"},     longint'(busy), 0);
      chk({pfx, "_grant_id"}, longint'(grant_id), 0);
      chk({pfx, "_cnt_load"}, longint'(cnt_load), 0);
      chk({pfx, "_cnt_cin"},  longint'(cnt_cin), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c, l0, i0;

      // reset state
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;

      // single pass from 0xFC
      step();
      c = cyc; l0 = n_load; i0 = n_cin;
      req_data[7:0] = 8'hFC; req_reps[3:0] = 4'd0; req[0] = 1'b1;
      push(1'b0, 0, c); push(1'b1, 0, c + 6);
      wait_ack(0, 4);
      step(); req[0] = 1'b0;
      wait_idle(20);
      chk("t1_idle_cycle", cyc, c + 7);
      chk("t1_loads", n_load - l0, 1);
      chk("t1_cin_cycles", n_cin - i0, 4);

      // three passes from 0xFE
      step();
      c = cyc; l0 = n_load; i0 = n_cin;
      req_data[15:8] = 8'hFE; req_reps[7:4] = 4'd2; req[1] = 1'b1;
      push(1'b0, 1, c); push(1'b1, 1, c + 10);
      wait_ack(1, 4);
      step(); req[1] = 1'b0;
      wait_idle(40);
      chk("t2_idle_cycle", cyc, c + 11);
      chk("t2_loads", n_load - l0, 3);
      chk("t2_cin_cycles", n_cin - i0, 6);
      chk("t2_counter_out", cnt_out, 0);

      // both requesters held: grants must alternate 0,1,0,1
      step();
      c = cyc;
      req_data = 16'hFFFF; req_reps = '0; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         push(1'b0, k % 2, c + 4 * k);
         push(1'b1, k % 2, c + 4 * k + 3);
      end
      while (cyc != c + 13) step();
      req = 2'b00;
      wait_idle(20);

      // hold for 5 cycles mid-RUN: done shifts from c+18 to c+23
      step();
      c = cyc; i0 = n_cin;
      req_data[7:0] = 8'hF0; req_reps[3:0] = 4'd0; req[0] = 1'b1;
      push(1'b0, 0, c); push(1'b1, 0, c + 23);
      wait_ack(0, 4);
      step(); req[0] = 1'b0;
      while (cyc != c + 5) step();
      hold = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_cin", longint'(cnt_cin), 0);
         step();
      end
      hold = 1'b0;
      wait_idle(40);
      chk("t4_cin_cycles", n_cin - i0, 16);

      // asynchronous reset during RUN of requester 1
      step();
      req_data[15:8] = 8'h00; req_reps[7:4] = 4'd0; req[1] = 1'b1;
      push(1'b0, 1, cyc);
      wait_ack(1, 4);
      step(); req[1] = 1'b0;
      repeat (8) step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      chk("rst_queue_empty", exp_q.size(), 0);
      repeat (2) step();
      rst_n = 1'b1;

      // after reset requester 0 wins first; 0x00 gives 256 RUN cycles
      step();
      c = cyc; i0 = n_cin;
      req_data = {8'hFF, 8'h00}; req_reps = '0; req = 2'b11;
      push(1'b0, 0, c);       push(1'b1, 0, c + 258);
      push(1'b0, 1, c + 259); push(1'b1, 1, c + 262);
      wait_ack(0, 4);
      step(); req[0] = 1'b0;
      wait_ack(1, 300);
      step(); req[1] = 1'b0;
      wait_idle(20);
      chk("t6_cin_cycles", n_cin - i0, 257);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
